// File: rtl/psum_accumulator_pkg.sv
// Shared constants and state encoding for the partial-sum accumulator.
// Imported by the accumulator top, its lane adder and its bus interface.
package psum_accumulator_pkg;

    localparam int LANES  = 16;
    localparam int PSUM_W = 24;
    localparam int ROWS   = 16;
    localparam int ROW_W  = LANES * PSUM_W;
    localparam int PTR_W  = $clog2(ROWS);

    localparam logic [PSUM_W-1:0] PSUM_MAX = 24'h7FFFFF;
    localparam logic [PSUM_W-1:0] PSUM_MIN = 24'h800000;
    localparam logic [PTR_W-1:0]  LAST_ROW = PTR_W'(ROWS - 1);

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ACCUM = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t FIN   = 2'd3;

endpackage

// File: rtl/psum_accumulator_if.sv
// Row bus between the systolic array, the accumulator and the ppu.
// slave = accumulator side; master = the array/ppu (or bench) side.
interface psum_accumulator_if;
    import psum_accumulator_pkg::*;

    logic             in_valid;
    logic [ROW_W-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [ROW_W-1:0] out_data;
    logic             out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/psum_accumulator_sat_add.sv
// One-lane signed saturating adder; overflow is detected from the two top bits
// of a sign-extended sum and clamped to the nearest representable extreme.
module psum_sat_add
    import psum_accumulator_pkg::*;
(
    input  logic [PSUM_W-1:0] a_i,
    input  logic [PSUM_W-1:0] b_i,
    output logic [PSUM_W-1:0] sum_o,
    output logic              sat_o
);

    logic [PSUM_W:0] wide_s;

    // sign-extended add followed by clamp
    always_comb begin
        wide_s = {a_i[PSUM_W-1], a_i} + {b_i[PSUM_W-1], b_i};
        if (wide_s[PSUM_W] != wide_s[PSUM_W-1]) begin
            sat_o = 1'b1;
            sum_o = wide_s[PSUM_W] ? PSUM_MIN : PSUM_MAX;
        end else begin
            sat_o = 1'b0;
            sum_o = wide_s[PSUM_W-1:0];
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates num_k passes of partial-sum rows into a row buffer with per-lane
// saturation, then drains the finished tile to the ppu under ready/valid.
module psum_accumulator
    import psum_accumulator_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [3:0]          num_k_i,
    psum_accumulator_if.slave   bus_if,
    output logic                busy_o,
    output logic                done_o,
    output logic                sat_flag_o
);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   row_ptr_q;
    logic [PTR_W-1:0]   drain_ptr_q;
    logic [4:0]         pass_cnt_q;
    logic [4:0]         num_k_q;
    logic               sat_flag_q;
    logic [ROW_W-1:0]   out_data_q;
    logic [ROW_W-1:0]   row_buf_q [ROWS];

    logic [ROW_W-1:0]   cur_row_s;
    logic [ROW_W-1:0]   sum_row_s;
    logic [LANES-1:0]   lane_sat_s;
    logic               in_xfer_s;
    logic               out_xfer_s;
    logic               last_in_s;
    logic               last_out_s;

    assign cur_row_s  = row_buf_q[row_ptr_q];
    assign in_xfer_s  = (state_q == ACCUM) && bus_if.in_valid;
    assign out_xfer_s = (state_q == DRAIN) && bus_if.out_ready;
    assign last_in_s  = in_xfer_s && (row_ptr_q == LAST_ROW) && (pass_cnt_q == (num_k_q - 5'd1));
    assign last_out_s = out_xfer_s && (drain_ptr_q == LAST_ROW);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        psum_sat_add u_sat_add (
            .a_i   (cur_row_s[g*PSUM_W +: PSUM_W]),
            .b_i   (bus_if.in_data[g*PSUM_W +: PSUM_W]),
            .sum_o (sum_row_s[g*PSUM_W +: PSUM_W]),
            .sat_o (lane_sat_s[g])
        );
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)    state_d = ACCUM; else state_d = IDLE;
            ACCUM:   if (last_in_s)  state_d = DRAIN; else state_d = ACCUM;
            DRAIN:   if (last_out_s) state_d = FIN;   else state_d = DRAIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from registered state and registered drain data
    always_comb begin
        busy_o           = (state_q != IDLE);
        done_o           = (state_q == FIN);
        sat_flag_o       = sat_flag_q;
        bus_if.in_ready  = (state_q == ACCUM);
        bus_if.out_valid = (state_q == DRAIN);
        bus_if.out_data  = out_data_q;
    end

    // tile control: pointers, pass counter, sticky saturation, drain data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_ptr_q   <= '0;
            drain_ptr_q <= '0;
            pass_cnt_q  <= 5'd0;
            num_k_q     <= 5'd0;
            sat_flag_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        num_k_q     <= (num_k_i == 4'd0) ? 5'd16 : {1'b0, num_k_i};
                        sat_flag_q  <= 1'b0;
                        row_ptr_q   <= '0;
                        pass_cnt_q  <= 5'd0;
                        drain_ptr_q <= '0;
                    end
                end
                ACCUM: begin
                    if (in_xfer_s) begin
                        row_ptr_q <= row_ptr_q + 1'b1;
                        if (row_ptr_q == LAST_ROW) begin
                            pass_cnt_q <= pass_cnt_q + 5'd1;
                        end
                        if ((pass_cnt_q != 5'd0) && (|lane_sat_s)) begin
                            sat_flag_q <= 1'b1;
                        end
                    end
                    // row 0 is already final when the last row of the last pass lands
                    if (last_in_s) begin
                        out_data_q  <= row_buf_q[0];
                        drain_ptr_q <= '0;
                    end
                end
                DRAIN: begin
                    if (out_xfer_s) begin
                        drain_ptr_q <= drain_ptr_q + 1'b1;
                        out_data_q  <= last_out_s ? '0 : row_buf_q[drain_ptr_q + 1'b1];
                    end
                end
                default: begin
                    out_data_q <= '0;
                end
            endcase
        end
    end

    // row buffer: first pass overwrites, later passes saturate-accumulate
    always_ff @(posedge clk) begin
        if (in_xfer_s) begin
            row_buf_q[row_ptr_q] <= (pass_cnt_q == 5'd0) ? bus_if.in_data : sum_row_s;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed, table-driven bench for psum_accumulator: each vector is a whole
// tile with hand-computed drained lane values, plus a mid-tile reset sequence.
module tb_psum_accumulator;
    import psum_accumulator_pkg::*;

    typedef struct {
        logic [3:0]  num_k;
        logic        row_mode;
        int          row_k;
        logic [23:0] in0, in1, inx;
        logic [23:0] ex0, ex1, exx;
        logic        exp_sat;
        logic        gaps;
        logic        bp;
        logic        start_in_drain;
    } vec_t;

    vec_t vecs [6];

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] num_k;
    logic       busy, done, sat_flag;
    int         checks = 0;
    int         failures = 0;

    psum_accumulator_if bus ();

    psum_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .num_k_i    (num_k),
        .bus_if     (bus),
        .busy_o     (busy),
        .done_o     (done),
        .sat_flag_o (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] row_of(input logic [23:0] l0, input logic [23:0] l1,
                                                 input logic [23:0] lx, input logic add, input int k,
                                                 input int r);
        logic [ROW_W-1:0] d;
        logic [23:0] v;
        for (int l = 0; l < LANES; l++) begin
            v = (l == 0) ? l0 : (l == 1) ? l1 : lx;
            if (add) v = v + 24'(k * r);
            d[l*PSUM_W +: PSUM_W] = v;
        end
        return d;
    endfunction

    task automatic run_tile(input vec_t v, input string tag);
        int total, sent, cyc, rows;
        total = 16 * ((v.num_k == 4'd0) ? 16 : int'(v.num_k));
        @(negedge clk);
        start = 1'b1;
        num_k = v.num_k;
        @(negedge clk);
        start = 1'b0;
        num_k = 4'd5;
        chk({tag, "_busy_after_start"}, int'(busy), 1);
        chk({tag, "_sat_cleared_on_start"}, int'(sat_flag), 0);
        sent = 0;
        cyc = 0;
        while (sent < total && cyc < 4000) begin
            if (v.gaps && (cyc % 5 == 3)) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = row_of(v.in0, v.in1, v.inx, v.row_mode, 1, sent % 16);
                if (bus.in_ready) sent++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_rows_accepted"}, sent, total);
        chk({tag, "_in_ready_drop"}, int'(bus.in_ready), 0);
        chk({tag, "_first_out_valid"}, int'(bus.out_valid), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = '1;
        rows = 0;
        cyc = 0;
        while (rows < 16 && cyc < 200) begin
            chk($sformatf("%s_out_valid_r%0d", tag, rows), int'(bus.out_valid), 1);
            chk_row($sformatf("%s_out_data_r%0d", tag, rows), bus.out_data,
                    row_of(v.ex0, v.ex1, v.exx, v.row_mode, v.row_k, rows));
            chk($sformatf("%s_no_early_done_c%0d", tag, cyc), int'(done), 0);
            bus.out_ready = v.bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            start = v.start_in_drain && (cyc == 1);
            if (bus.out_ready) rows++;
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        start = 1'b0;
        chk({tag, "_rows_drained"}, rows, 16);
        chk({tag, "_done_pulse"}, int'(done), 1);
        chk({tag, "_fin_out_valid"}, int'(bus.out_valid), 0);
        chk_row({tag, "_fin_out_data"}, bus.out_data, '0);
        chk({tag, "_sat_flag"}, int'(sat_flag), int'(v.exp_sat));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_sat_sticky"}, int'(sat_flag), int'(v.exp_sat));
        @(negedge clk);
        chk({tag, "_start_not_queued"}, int'(busy), 0);
    endtask

    initial begin
        int sent, cyc;
        // num_k, row_mode, row_k, in0, in1, inx, ex0, ex1, exx, sat, gaps, bp, start_in_drain
        vecs[0] = '{4'd1, 1'b1, 1, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'd3, 1'b0, 0, 24'h000010, 24'h000010, 24'h000010,
                    24'h000030, 24'h000030, 24'h000030, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{4'd2, 1'b0, 0, 24'h700000, 24'h900000, 24'h000001,
                    24'h7FFFFF, 24'h800000, 24'h000002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'd0, 1'b0, 0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                    24'hFFFFF0, 24'hFFFFF0, 24'hFFFFF0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'd2, 1'b0, 0, 24'h3FFFFF, 24'hC00000, 24'h123456,
                    24'h7FFFFE, 24'h800000, 24'h2468AC, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'd2, 1'b1, 2, 24'h000100, 24'hFFFF00, 24'h000005,
                    24'h000200, 24'hFFFE00, 24'h00000A, 1'b0, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        num_k = 4'd0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_sat", int'(sat_flag), 0);
        chk("reset_in_ready", int'(bus.in_ready), 0);
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk_row("reset_out_data", bus.out_data, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", int'(bus.in_ready), 0);

        for (int i = 0; i < 6; i++) begin
            run_tile(vecs[i], $sformatf("v%0d", i));
        end

        // reset in pass 1 at row 7, then a clean tile must not see stale data
        @(negedge clk);
        start = 1'b1;
        num_k = 4'd2;
        @(negedge clk);
        start = 1'b0;
        sent = 0;
        cyc = 0;
        while (sent < 23 && cyc < 100) begin
            bus.in_valid = 1'b1;
            bus.in_data  = row_of(24'h555555, 24'h555555, 24'h555555, 1'b0, 0, 0);
            if (bus.in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("rstmid_rows_accepted", sent, 23);
        chk("rstmid_pre_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_in_ready", int'(bus.in_ready), 0);
        chk("rstmid_out_valid", int'(bus.out_valid), 0);
        chk("rstmid_done", int'(done), 0);
        chk_row("rstmid_out_data", bus.out_data, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_no_done", int'(done), 0);
        chk("rstmid_idle", int'(busy), 0);
        run_tile(vecs[0], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly upstream of the post-processing unit (ppu).
- Collects 16-lane x 24-bit partial-sum rows from the systolic array over num_k K-passes.
- Accumulates each row in a 16-row buffer with signed saturation.
- Drains the finished rows in order to the ppu's partial_sum/valid input under a ready handshake.

Parameters:
- LANES, 16, lanes per row (partial_sum = LANES*PSUM_W = 384 bits)
- PSUM_W, 24, signed lane width
- ROWS, 16, rows per output tile (buffer depth)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a tile; sampled only in IDLE
- num_k  in  4  K-passes per tile; value n means n passes, except 0, which means 16; latched on start
- in_valid  in  1  array row valid
- in_data  in  384  array row, lane i = bits [24i+23:24i]
- in_ready  out  1  accepting rows (high only in ACCUM)
- out_valid  out  1  row available to ppu
- out_data  out  384  row to ppu partial_sum
- out_ready  in  1  ppu accepts row
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last row drained
- sat_flag  out  1  sticky; any lane saturated this tile

Behaviour:
- Reset values: all outputs 0, state IDLE, row_ptr/pass_cnt/drain_ptr 0.
  - Buffer contents are not reset (don't-care); the first pass overwrites them.
  - Reset mid-tile aborts immediately with no done pulse.
- States: IDLE, ACCUM, DRAIN, FIN.
- IDLE:
  - start=1 -> ACCUM next cycle.
  - On that edge: latch num_k (0 -> 16), clear sat_flag, row_ptr=0, pass_cnt=0.
- ACCUM:
  - in_ready=1. A row transfers on in_valid & in_ready.
  - pass_cnt==0: buf[row_ptr] <= in_data (overwrite).
  - Otherwise: per-lane buf[row_ptr] <= sat(buf + in).
  - row_ptr increments on each transfer. At 15 it wraps to 0 and pass_cnt increments.
  - The transfer at row 15 of the last pass -> DRAIN next cycle.
- Saturating add:
  - Signed 25-bit intermediate per lane.
  - Result > 0x7FFFFF clamps to 0x7FFFFF; result < -0x800000 clamps to 0x800000.
  - Any clamp sets sat_flag (sticky until next start).
- DRAIN:
  - out_valid=1 and out_data = buf[drain_ptr], registered.
  - The first out_valid appears in the cycle after the final ACCUM transfer (1-cycle latency).
  - drain_ptr advances on out_valid & out_ready. out_data updates the cycle after a transfer; no bubble is required.
  - With out_ready low, out_valid and out_data hold stable.
  - The transfer with drain_ptr==15 -> FIN.
- FIN: done=1 for exactly one cycle -> IDLE. out_valid=0 and out_data=0 whenever not in DRAIN.
- Ignored inputs:
  - in_valid outside ACCUM has no effect.
  - start outside IDLE is ignored; it is not queued.
- Minimum tile length: 16*num_k accepted rows + 16 drain transfers + 1 FIN cycle.

Decomposition:
- Shared package:
  - LANES, PSUM_W, ROWS.
  - PSUM_MAX=24'h7FFFFF, PSUM_MIN=24'h800000.
  - State encoding localparams IDLE/ACCUM/DRAIN/FIN.
- Sub-module psum_sat_add:
  - Combinational, one lane: a, b (PSUM_W signed) -> sum, sat.
  - Instantiated LANES times with a generate loop.

Test Plan:
- num_k=1, rows r=0..15 all lanes = r, out_ready=1:
  - Drain yields row r lanes = r in order.
  - First out_valid 1 cycle after 16th input; done pulses once after 16th drain; sat_flag=0.
- num_k=3, every lane = 24'h000010 each pass:
  - All drained lanes = 24'h000030.
  - in_ready drops after exactly 48 transfers.
- Saturation, num_k=2, lane 0 = 24'h700000 both passes, lane 1 = 24'h900000 both passes:
  - Lane 0 = 24'h7FFFFF, lane 1 = 24'h800000, sat_flag=1.
  - Next start clears sat_flag.
- Backpressure:
  - out_ready toggled 1,0,0,1 during DRAIN: out_data/out_valid hold while low.
  - Exactly 16 rows drained with no duplicates or skips.
  - in_valid gaps during ACCUM stall without corrupting row_ptr.
- num_k=0: the tile consumes 256 input rows (16 passes); all-ones lanes (24'hFFFFFF = -1) drain as 24'hFFFFF0 (-16).
- rst asserted mid-ACCUM (pass 1, row 7):
  - Outputs immediately 0, state IDLE, no done.
  - A fresh start with num_k=1 completes normally; stale buffer data is not visible.
